// File: rtl/alu_issue_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_decoder
// Purpose  : Registered decode-and-issue stage in front of the integer ALU.
//            Decodes RV32I OP / OP-IMM (and optionally LUI / AUIPC) into an
//            ALU enable, an ALU_OP_* code and A/B operands, then queues the
//            result in a 2-entry skid buffer so the ALU side can stall
//            without a combinational ready path back to the producer.
// Ports    : clk, rst_n (sync, active-low), flush (drop all buffered entries)
//            in_valid/in_ready, instr, pc, rs1_val, rs2_val   - issue side
//            out_valid/out_ready, alu_e, alu_op, alu_a, alu_b,
//            rd, illegal                                      - ALU side
// Config   : `define ALU_ISSUE_UPPER_IMM_EN to decode LUI / AUIPC; when
//            undefined both are illegal and pc is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_decoder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] rs1_val,
    input  logic [DATA_WIDTH-1:0] rs2_val,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  alu_e,
    output logic [5:0]            alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [4:0]            rd,
    output logic                  illegal
);

    // ALU operation codes (IntegerBasicALU_OpCodes.vh encoding)
    localparam logic [5:0] c_ALU_OP_PLUS            = 6'd1;
    localparam logic [5:0] c_ALU_OP_SUB             = 6'd2;
    localparam logic [5:0] c_ALU_OP_SHIFT_LEFT      = 6'd3;
    localparam logic [5:0] c_ALU_OP_SHIFT_RIGHT     = 6'd4;
    localparam logic [5:0] c_ALU_OP_SHIFT_RIGHT_A   = 6'd5;
    localparam logic [5:0] c_ALU_OP_SET_LESS_THAN   = 6'd6;
    localparam logic [5:0] c_ALU_OP_SET_LESS_THAN_U = 6'd7;
    localparam logic [5:0] c_ALU_OP_XOR             = 6'd8;
    localparam logic [5:0] c_ALU_OP_OR              = 6'd9;
    localparam logic [5:0] c_ALU_OP_AND             = 6'd10;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_F7_ZERO    = 7'b0000000;
    localparam logic [6:0] c_F7_ALT     = 7'b0100000;

    typedef struct packed {
        logic                  illegal;
        logic [4:0]            rd;
        logic [5:0]            op;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
    } entry_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic [6:0]            w_funct7;
    logic [DATA_WIDTH-1:0] w_imm_i;
    logic [DATA_WIDTH-1:0] w_imm_u;
    logic [DATA_WIDTH-1:0] w_shamt_r;
    logic [DATA_WIDTH-1:0] w_shamt_i;
    logic                  w_illegal;
    logic [5:0]            w_op;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    entry_t                w_new;

    assign w_opcode  = instr[6:0];
    assign w_funct3  = instr[14:12];
    assign w_funct7  = instr[31:25];
    assign w_imm_i   = DATA_WIDTH'($signed(instr[31:20]));
    assign w_imm_u   = DATA_WIDTH'($signed({instr[31:12], 12'b0}));
    // The ALU shifts by the whole B operand, so shift amounts are masked
    // down to 5 bits here.
    assign w_shamt_r = DATA_WIDTH'(rs2_val[4:0]);
    assign w_shamt_i = DATA_WIDTH'(instr[24:20]);

    always_comb begin
        w_illegal = 1'b1;
        w_op      = '0;
        w_a       = '0;
        w_b       = '0;
        case (w_opcode)
            c_OPC_OP: begin
                w_a       = rs1_val;
                w_b       = rs2_val;
                w_illegal = (w_funct7 != c_F7_ZERO);
                case (w_funct3)
                    3'b000: begin
                        w_op      = (w_funct7 == c_F7_ALT) ? c_ALU_OP_SUB : c_ALU_OP_PLUS;
                        w_illegal = (w_funct7 != c_F7_ZERO) && (w_funct7 != c_F7_ALT);
                    end
                    3'b001: begin
                        w_op = c_ALU_OP_SHIFT_LEFT;
                        w_b  = w_shamt_r;
                    end
                    3'b010: w_op = c_ALU_OP_SET_LESS_THAN;
                    3'b011: w_op = c_ALU_OP_SET_LESS_THAN_U;
                    3'b100: w_op = c_ALU_OP_XOR;
                    3'b101: begin
                        w_op      = (w_funct7 == c_F7_ALT) ? c_ALU_OP_SHIFT_RIGHT_A
                                                           : c_ALU_OP_SHIFT_RIGHT;
                        w_b       = w_shamt_r;
                        w_illegal = (w_funct7 != c_F7_ZERO) && (w_funct7 != c_F7_ALT);
                    end
                    3'b110: w_op = c_ALU_OP_OR;
                    default: w_op = c_ALU_OP_AND;
                endcase
            end
            c_OPC_OP_IMM: begin
                w_a       = rs1_val;
                w_b       = w_imm_i;
                w_illegal = 1'b0;
                case (w_funct3)
                    3'b000: w_op = c_ALU_OP_PLUS;
                    3'b001: begin
                        w_op      = c_ALU_OP_SHIFT_LEFT;
                        w_b       = w_shamt_i;
                        w_illegal = (instr[31:25] != 7'b0);
                    end
                    3'b010: w_op = c_ALU_OP_SET_LESS_THAN;
                    3'b011: w_op = c_ALU_OP_SET_LESS_THAN_U;
                    3'b100: w_op = c_ALU_OP_XOR;
                    3'b101: begin
                        w_op      = (instr[30]) ? c_ALU_OP_SHIFT_RIGHT_A : c_ALU_OP_SHIFT_RIGHT;
                        w_b       = w_shamt_i;
                        // instr[25] would be shamt[5] on RV64; always illegal here
                        w_illegal = instr[25] ||
                                    ((instr[31:26] != 6'b000000) && (instr[31:26] != 6'b010000));
                    end
                    3'b110: w_op = c_ALU_OP_OR;
                    default: w_op = c_ALU_OP_AND;
                endcase
            end
`ifdef ALU_ISSUE_UPPER_IMM_EN
            c_OPC_LUI: begin
                w_op      = c_ALU_OP_PLUS;
                w_b       = w_imm_u;
                w_illegal = 1'b0;
            end
            c_OPC_AUIPC: begin
                w_op      = c_ALU_OP_PLUS;
                w_a       = pc;
                w_b       = w_imm_u;
                w_illegal = 1'b0;
            end
`endif
            default: w_illegal = 1'b1;
        endcase
        // Illegal entries carry only rd; everything else is forced to zero.
        if (w_illegal) begin
            w_op = '0;
            w_a  = '0;
            w_b  = '0;
        end
    end

`ifndef ALU_ISSUE_UPPER_IMM_EN
    // pc and the U-immediate-only bits feed nothing in this build.
    logic w_unused_upper_imm;
    assign w_unused_upper_imm = ^{pc, w_imm_u, c_OPC_LUI, c_OPC_AUIPC};
`endif

    assign w_new = '{illegal: w_illegal, rd: instr[11:7], op: w_op, a: w_a, b: w_b};

    // ------------------------------------------------------------------
    // Two-entry skid buffer; r_slot0 is always the head.
    // ------------------------------------------------------------------
    logic [1:0] r_count;
    logic       r_in_ready;
    entry_t     r_slot0;
    entry_t     r_slot1;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_count_nxt;

    // in_ready is only ever 1 when occupancy <= 1, so a push never
    // targets a full buffer.
    assign w_push      = in_valid && r_in_ready;
    assign w_pop       = (r_count != 2'd0) && out_ready;
    assign w_count_nxt = flush ? 2'd0
                               : (r_count + {1'b0, w_push} - {1'b0, w_pop});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
            r_slot0    <= '0;
            r_slot1    <= '0;
        end else begin
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != 2'd2);
            if (!flush) begin
                case ({w_push, w_pop})
                    2'b11: begin
                        if (r_count == 2'd1) begin
                            r_slot0 <= w_new;
                        end else begin
                            r_slot0 <= r_slot1;
                            r_slot1 <= w_new;
                        end
                    end
                    2'b10: begin
                        if (r_count == 2'd0) r_slot0 <= w_new;
                        else                 r_slot1 <= w_new;
                    end
                    2'b01:   r_slot0 <= r_slot1;
                    default: ;
                endcase
            end
        end
    end

    // Data outputs are gated so an empty buffer presents all zeros.
    entry_t w_head;
    assign out_valid = (r_count != 2'd0);
    assign w_head    = out_valid ? r_slot0 : '0;
    assign in_ready  = r_in_ready;
    assign alu_e     = out_valid && !w_head.illegal;
    assign alu_op    = w_head.op;
    assign alu_a     = w_head.a;
    assign alu_b     = w_head.b;
    assign rd        = w_head.rd;
    assign illegal   = w_head.illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_decoder
// Purpose  : Scoreboard bench for alu_issue_decoder. Stimulus pushes the
//            hand-computed expected entry when a handshake is certain; a
//            monitor pops and compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_decoder;

    localparam logic [5:0] c_PLUS  = 6'd1;
    localparam logic [5:0] c_SUB   = 6'd2;
    localparam logic [5:0] c_SLL   = 6'd3;
    localparam logic [5:0] c_SRA   = 6'd5;
    localparam logic [5:0] c_XOR   = 6'd8;

    typedef struct packed {
        logic        e;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, pc, rs1_val, rs2_val, alu_a, alu_b;
    logic        alu_e, illegal;
    logic [5:0]  alu_op;
    logic [4:0]  rd;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    alu_issue_decoder #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_e(alu_e), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .rd(rd), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t ok(input logic [5:0] op, input logic [31:0] a, b,
                                input logic [4:0] r);
        return '{e: 1'b1, op: op, a: a, b: b, rd: r, ill: 1'b0};
    endfunction

    function automatic exp_t bad(input logic [4:0] r);
        return '{e: 1'b0, op: 6'd0, a: 32'd0, b: 32'd0, rd: r, ill: 1'b1};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every output handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t got;
            got = '{e: alu_e, op: alu_op, a: alu_a, b: alu_b, rd: rd, ill: illegal};
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_issue: got %h, expected nothing", got);
            end else begin
                exp_t req;
                req = sb.pop_front();
                if (got !== req) begin
                    n_err++;
                    $display("FAIL issue: got e=%0b op=%0d a=%h b=%h rd=%0d ill=%0b, expected e=%0b op=%0d a=%h b=%h rd=%0d ill=%0b",
                             got.e, got.op, got.a, got.b, got.rd, got.ill,
                             req.e, req.op, req.a, req.b, req.rd, req.ill);
                end
            end
        end
    end

    // Present one input and hold it until accepted (bounded wait).
    task automatic issue(input logic [31:0] ins, p, r1, r2, input exp_t e);
        int n;
        n = 0;
        in_valid = 1'b1;
        instr    = ins;
        pc       = p;
        rs1_val  = r1;
        rs2_val  = r2;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: in_ready got 0, expected 1 within 50 cycles");
        end else begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic fill_two();
        out_ready = 1'b0;
        issue(32'h002081B3, 32'h0, 32'hA, 32'hB, ok(c_PLUS, 32'hA, 32'hB, 5'd3));
        issue(32'h002081B3, 32'h0, 32'hC, 32'hD, ok(c_PLUS, 32'hC, 32'hD, 5'd3));
        @(negedge clk);
        chk("fill_out_valid", 32'(out_valid), 32'd1);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; pc = '0; rs1_val = '0; rs2_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_alu_a", alu_a, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // ADD x3,x1,x2 with 1-cycle latency
        issue(32'h002081B3, 32'h0, 32'd5, 32'd7, ok(c_PLUS, 32'd5, 32'd7, 5'd3));
        chk("add_latency_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        issue(32'h402081B3, 32'h0, 32'd5, 32'hFFFFFF21, ok(c_SUB, 32'd5, 32'hFFFFFF21, 5'd3));
        issue(32'h002091B3, 32'h0, 32'd5, 32'hFFFFFF21, ok(c_SLL, 32'd5, 32'h1, 5'd3));
        issue(32'h0020C233, 32'h0, 32'hF0F0, 32'h0FF0, ok(c_XOR, 32'hF0F0, 32'h0FF0, 5'd4));
        issue(32'h022081B3, 32'h0, 32'd5, 32'd7, bad(5'd3));   // funct7 0000001
        issue(32'h4040D093, 32'h0, 32'h80000000, 32'd9, ok(c_SRA, 32'h80000000, 32'd4, 5'd1));
        issue(32'h02009093, 32'h0, 32'h1234, 32'd9, bad(5'd1)); // SLLI with instr[25]=1
        issue(32'hFFF08113, 32'h0, 32'd100, 32'd0, ok(c_PLUS, 32'd100, 32'hFFFFFFFF, 5'd2));
        issue(32'h0000006F, 32'h0, 32'd1, 32'd2, bad(5'd0));    // JAL: unknown opcode
`ifdef ALU_ISSUE_UPPER_IMM_EN
        issue(32'h123452B7, 32'h0, 32'd9, 32'd9, ok(c_PLUS, 32'd0, 32'h12345000, 5'd5));
        issue(32'h12345297, 32'h1000, 32'd9, 32'd9, ok(c_PLUS, 32'h1000, 32'h12345000, 5'd5));
`else
        issue(32'h123452B7, 32'h0, 32'd9, 32'd9, bad(5'd5));
        issue(32'h12345297, 32'h1000, 32'd9, 32'd9, bad(5'd5));
`endif
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: three back-to-back inputs against a stalled ALU
        out_ready = 1'b0;
        issue(32'h002081B3, 32'h0, 32'h11, 32'h1, ok(c_PLUS, 32'h11, 32'h1, 5'd3));
        issue(32'h002081B3, 32'h0, 32'h22, 32'h2, ok(c_PLUS, 32'h22, 32'h2, 5'd3));
        fork
            issue(32'h002081B3, 32'h0, 32'h33, 32'h3, ok(c_PLUS, 32'h33, 32'h3, 5'd3));
            begin
                @(negedge clk);
                chk("full_in_ready", 32'(in_ready), 32'd0);
                repeat (2) @(negedge clk);
                chk("stall_head_a", alu_a, 32'h11);
                chk("stall_head_b", alu_b, 32'h1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Flush with a concurrent input: everything dropped
        fill_two();
        flush = 1'b1;
        in_valid = 1'b1;
        instr = 32'h002081B3; rs1_val = 32'h99; rs2_val = 32'h99;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("flush_nothing_issued", 32'(out_valid), 32'd0);

        // Reset mid-stream with a concurrent input
        @(posedge clk);
        #1;
        fill_two();
        rst_n = 1'b0;
        in_valid = 1'b1;
        instr = 32'h002081B3; rs1_val = 32'h77; rs2_val = 32'h77;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_nothing_issued", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
